cordic_vector: RTL

CORDIC_VECTOR -- requirements
Module: cordic_vector

---
 rtl/cordic_pkg.sv | 33 +++
 rtl/cordic_atan_lut.sv | 11 +
 rtl/cordic_vector.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared constants for the vectoring and rotation CORDIC blocks: sizes,
// the arctangent table and the angle clamp helper.
package cordic_pkg;

   localparam int ITERATIONS = 8;
   localparam int ITER_W     = $clog2(ITERATIONS);
   localparam int DATA_W     = 8;
   localparam int INT_W      = 10;

   // 1/K in 8-bit fixed point; the rotation block pre-scales with this.
   localparam logic [DATA_W-1:0] ROT_UNITY = 8'd155;

   // atan(2^-i) in units where 256 = 90 degrees.
   localparam logic [DATA_W-1:0] ATAN_TABLE [0:ITERATIONS-1] = '{
      8'd128, 8'd76, 8'd40, 8'd20, 8'd10, 8'd5, 8'd3, 8'd1
   };

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   function automatic logic [DATA_W-1:0] clamp_angle(input logic [INT_W-1:0] z);
      if (z[INT_W-1])
         return '0;
      else if (|z[INT_W-2:DATA_W])
         return '1;
      else
         return z[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/cordic_atan_lut.sv
// Combinational arctangent lookup, one entry per CORDIC micro-rotation.
module cordic_atan_lut
   import cordic_pkg::*;
(
   input  logic [ITER_W-1:0] idx,
   output logic [DATA_W-1:0] angle
);

   assign angle = ATAN_TABLE[idx];

endmodule

// File: rtl/cordic_vector.sv
// Iterative vectoring CORDIC: drives y to zero over eight micro-rotations,
// returning atan2(y, x) and the gain-scaled magnitude.
//
//   state  | meaning
//   IDLE   | waiting for START; last result held on ANGLE/MAG
//   RUN    | one micro-rotation per clock, iteration index 0..7
//   FINISH | latch clamped angle and magnitude, pulse DONE
module cordic_vector
   import cordic_pkg::*;
(
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic [DATA_W-1:0] X_IN,
   input  logic [DATA_W-1:0] Y_IN,
   output logic              BUSY,
   output logic              DONE,
   output logic [DATA_W-1:0] ANGLE,
   output logic [INT_W-1:0]  MAG
);

   state_t state, state_nxt;

   logic              capture, iterate, finish;
   logic [ITER_W-1:0] iter;
   logic [INT_W-1:0]  x, y, z;
   logic              zero_op;

   logic [DATA_W-1:0] atan_a;
   logic [INT_W-1:0]  a_ext, x_sh, y_sh;
   logic [INT_W-1:0]  x_nxt, y_nxt, z_nxt;
   logic              y_neg;

   cordic_atan_lut u_atan_lut (
      .idx   (iter),
      .angle (atan_a)
   );

   always_ff @(posedge CLK) begin
      if (!RESET)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      iterate   = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (START) begin
               capture   = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            iterate = 1'b1;
            if (iter == ITER_W'(ITERATIONS - 1))
               state_nxt = FINISH;
         end
         FINISH: begin
            finish    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // y and z are two's complement; x stays non-negative so a logical shift suffices.
   always_comb begin
      y_neg = y[INT_W-1];
      a_ext = INT_W'(atan_a);
      x_sh  = x >> iter;
      y_sh  = $signed(y) >>> iter;
      if (y_neg) begin
         x_nxt = x - y_sh;
         y_nxt = y + x_sh;
         z_nxt = z - a_ext;
      end else begin
         x_nxt = x + y_sh;
         y_nxt = y - x_sh;
         z_nxt = z + a_ext;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         x       <= '0;
         y       <= '0;
         z       <= '0;
         iter    <= '0;
         zero_op <= 1'b0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         ANGLE   <= '0;
         MAG     <= '0;
      end else begin
         DONE <= 1'b0;
         if (capture) begin
            x       <= INT_W'(X_IN);
            y       <= INT_W'(Y_IN);
            z       <= '0;
            iter    <= '0;
            zero_op <= (X_IN == '0) && (Y_IN == '0);
            BUSY    <= 1'b1;
         end else if (iterate) begin
            x    <= x_nxt;
            y    <= y_nxt;
            z    <= z_nxt;
            iter <= iter + 1'b1;
         end else if (finish) begin
            // The origin has no defined angle; report 0 rather than the accumulated sweep.
            ANGLE <= zero_op ? '0 : clamp_angle(z);
            MAG   <= x;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
         end
      end
   end

endmodule
